// File: rtl/regex_checker.sv
// Unanchored stream matcher for "a b{0,MAX_B} c d", popping one FIFO word per cycle.
// Define REGEX_CASE_INSENSITIVE_EN to also accept uppercase A-D.
module regex_checker #(
  parameter int WIDTH = 16,
  parameter int MAX_B = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_shift_out,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] char_count,
  output logic             busy
);

  // state    | meaning
  // S_IDLE   | no partial pattern
  // S_SEEN_A | seen 'a' plus b_cnt_q 'b's
  // S_SEEN_C | seen 'a' b* 'c', waiting for 'd'
  typedef enum logic [1:0] {S_IDLE, S_SEEN_A, S_SEEN_C} state_t;
  typedef enum logic [2:0] {C_A, C_B, C_C, C_D, C_OTHER} class_t;

  localparam logic [3:0]       MAX_B_L = 4'(MAX_B);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [3:0]       b_cnt_q, b_cnt_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] match_count_q, match_count_d;
  logic [CNT_W-1:0] char_count_q, char_count_d;
  logic [7:0]       chr;
  logic             upper_zero;
  class_t           cls;

  assign fifo_shift_out = res_n & enable & ~fifo_empty;
  assign upper_zero     = (fifo_data >> 8) == '0;

  always_comb begin
    chr = fifo_data[7:0];
`ifdef REGEX_CASE_INSENSITIVE_EN
    if (chr >= 8'h41 && chr <= 8'h44) chr = chr | 8'h20;
`endif
    cls = C_OTHER;
    if (upper_zero) begin
      case (chr)
        8'h61:   cls = C_A;
        8'h62:   cls = C_B;
        8'h63:   cls = C_C;
        8'h64:   cls = C_D;
        default: cls = C_OTHER;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    b_cnt_d       = b_cnt_q;
    match_d       = 1'b0;
    match_count_d = match_count_q;
    char_count_d  = char_count_q;
    if (fifo_shift_out) begin
      char_count_d = char_count_q + CNT_ONE;
      state_d      = S_IDLE;
      // 'a' restarts the pattern from every state
      if (cls == C_A) begin
        state_d = S_SEEN_A;
        b_cnt_d = 4'd0;
      end else begin
        case (state_q)
          S_SEEN_A: begin
            if (cls == C_B && b_cnt_q < MAX_B_L) begin
              state_d = S_SEEN_A;
              b_cnt_d = b_cnt_q + 4'd1;
            end else if (cls == C_C) begin
              state_d = S_SEEN_C;
            end
          end
          S_SEEN_C: begin
            if (cls == C_D) begin
              match_d = 1'b1;
              if (match_count_q != '1) match_count_d = match_count_q + CNT_ONE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q       <= S_IDLE;
      b_cnt_q       <= 4'd0;
      match_q       <= 1'b0;
      match_count_q <= '0;
      char_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      b_cnt_q       <= b_cnt_d;
      match_q       <= match_d;
      match_count_q <= match_count_d;
      char_count_q  <= char_count_d;
    end
  end

  assign match       = match_q;
  assign match_count = match_count_q;
  assign char_count  = char_count_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_regex_checker.sv
// Scoreboard bench: the driver acts as the FIFO and queues expected match counts,
// a negedge monitor pops one entry per match pulse on each of two DUT widths.
module tb_regex_checker;
  logic        clk = 1'b0;
  logic        res_n = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_data = 16'h0000;

  logic       shift_a, match_a, busy_a;
  logic [7:0] mc_a, cc_a;
  logic       shift_b, match_b, busy_b;
  logic [1:0] mc_b, cc_b;

  int checks = 0;
  int failures = 0;
  int exp_a[$];
  int exp_b[$];

  always #5 clk = ~clk;

  regex_checker #(.WIDTH(16), .MAX_B(4), .CNT_W(8)) dut (
    .clk(clk), .res_n(res_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_shift_out(shift_a), .match(match_a),
    .match_count(mc_a), .char_count(cc_a), .busy(busy_a));

  regex_checker #(.WIDTH(16), .MAX_B(4), .CNT_W(2)) dut2 (
    .clk(clk), .res_n(res_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_shift_out(shift_b), .match(match_b),
    .match_count(mc_b), .char_count(cc_b), .busy(busy_b));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every match pulse must correspond to a queued expectation.
  always @(negedge clk) begin
    if (match_a) begin
      if (exp_a.size() == 0) chk("unexpected_match_a", 1, 0);
      else chk("match_count_a", int'(mc_a), exp_a.pop_front());
    end
    if (match_b) begin
      if (exp_b.size() == 0) chk("unexpected_match_b", 1, 0);
      else chk("match_count_b", int'(mc_b), exp_b.pop_front());
    end
  end

  task automatic send(input logic [15:0] w);
    @(negedge clk);
    res_n = 1'b1; enable = 1'b1; fifo_empty = 1'b0; fifo_data = w;
    #1 chk("shift_out_pop", int'(shift_a), 1);
  endtask

  task automatic idle(input int n, input int exp_busy);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fifo_empty = 1'b1; fifo_data = 16'h0064;
      #1 chk("shift_out_empty", int'(shift_a), 0);
      if (exp_busy >= 0) chk("busy_hold", int'(busy_a), exp_busy);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    res_n = 1'b0; enable = 1'b1; fifo_empty = 1'b0; fifo_data = 16'h0064;
    #1 chk("shift_out_in_reset", int'(shift_a), 0);
    @(negedge clk);
    res_n = 1'b1; fifo_empty = 1'b1;
    #1;
    chk("rst_match", int'(match_a), 0);
    chk("rst_match_count", int'(mc_a), 0);
    chk("rst_char_count", int'(cc_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_char_count_b", int'(cc_b), 0);
  endtask

  task automatic finish_test(input string name, input int mc, input int cc);
    idle(2, 0);
    chk({name, "_match_count"}, int'(mc_a), mc);
    chk({name, "_char_count"}, int'(cc_a), cc);
    chk({name, "_pending"}, exp_a.size() + exp_b.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // a b b c d
    send(16'h0061); send(16'h0062); send(16'h0062); send(16'h0063);
    exp_a.push_back(1); exp_b.push_back(1);
    send(16'h0064);
    finish_test("abbcd", 1, 5);

    // MAX_B+1 b's: rejected
    do_reset();
    send(16'h0061);
    for (int i = 0; i < 5; i++) send(16'h0062);
    send(16'h0063); send(16'h0064);
    finish_test("too_many_b", 0, 8);

    // exactly MAX_B b's: accepted
    do_reset();
    send(16'h0061);
    for (int i = 0; i < 4; i++) send(16'h0062);
    send(16'h0063);
    exp_a.push_back(1); exp_b.push_back(1);
    send(16'h0064);
    finish_test("max_b", 1, 7);

    // x a a c d a c d: restart on 'a', two matches
    do_reset();
    send(16'h0078); send(16'h0061); send(16'h0061); send(16'h0063);
    exp_a.push_back(1); exp_b.push_back(1);
    send(16'h0064);
    send(16'h0061); send(16'h0063);
    exp_a.push_back(2); exp_b.push_back(2);
    send(16'h0064);
    finish_test("restart", 2, 8);
    chk("restart_busy_end", int'(busy_a), 0);

    // FIFO empty mid-pattern, then enable low mid-pattern
    do_reset();
    send(16'h0061); send(16'h0063);
    idle(10, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      enable = 1'b0; fifo_empty = 1'b0; fifo_data = 16'h0062;
      #1 chk("shift_out_disabled", int'(shift_a), 0);
      chk("busy_disabled", int'(busy_a), 1);
    end
    chk("hold_char_count", int'(cc_a), 2);
    exp_a.push_back(1); exp_b.push_back(1);
    send(16'h0064);
    finish_test("hold", 1, 3);

    // 4 x acd: CNT_W=2 saturates match_count and wraps char_count
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      send(16'h0061); send(16'h0063);
      exp_a.push_back(i); exp_b.push_back(i > 3 ? 3 : i);
      send(16'h0064);
    end
    finish_test("sat", 4, 12);
    chk("sat_match_count_b", int'(mc_b), 3);
    chk("sat_char_count_b", int'(cc_b), 0);

    // reset mid-pattern discards progress
    do_reset();
    send(16'h0061); send(16'h0063);
    do_reset();
    send(16'h0064);
    finish_test("mid_reset", 0, 1);

    // upper bits nonzero: 0x0161 is not 'a'
    do_reset();
    send(16'h0161); send(16'h0063); send(16'h0064);
    finish_test("upper_bits", 0, 3);

    // uppercase A C D
    do_reset();
    send(16'h0041); send(16'h0043);
`ifdef REGEX_CASE_INSENSITIVE_EN
    exp_a.push_back(1); exp_b.push_back(1);
    send(16'h0044);
    finish_test("upper_case", 1, 3);
`else
    send(16'h0044);
    finish_test("upper_case", 0, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regex_checker.md
# regex_checker

Stream matcher that sits directly downstream of the character FIFO in the regular expression checker. It pops one character per clock from the FIFO whenever the FIFO is non-empty and `enable` is high. It runs an unanchored state machine for the pattern `a b{0,MAX_B} c d` over the character stream. It reports each match as a one-cycle pulse and keeps saturating match and character counters.

## Interface
- `WIDTH`, default 16: FIFO word width. Character is `fifo_data[7:0]`. Must be ≥ 8.
- `MAX_B`, default 4: maximum number of consecutive `b` accepted between `a` and `c`. Range 0..15.
- `CNT_W`, default 8: width of `match_count` and `char_count`.
- `clk` in, 1: single clock. All logic updates on the rising edge.
- `res_n` in, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `enable` in, 1: consume characters when high. When low, all state is held.
- `fifo_empty` in, 1: FIFO `empty` flag.
- `fifo_data` in, WIDTH: FIFO `data_out`. This is the head word, first-word-fall-through, valid whenever `fifo_empty` = 0.
- `fifo_shift_out` out, 1: FIFO `shift_out`. The head word is popped on the rising edge where this is high.
- `match` out, 1: one-cycle pulse, registered.
- `match_count` out, CNT_W: number of matches, saturates at all-ones.
- `char_count` out, CNT_W: number of characters consumed, wraps modulo 2^CNT_W.
- `busy` out, 1: high when the state machine is not in IDLE.

## Operation
- `fifo_shift_out = res_n & enable & ~fifo_empty`. This is combinational.
- A character is consumed on every edge where `fifo_shift_out` = 1. No other edge changes the state machine or the counters, with two exceptions:
  - reset
  - `match` returning to 0
- Character classification:
  - A word with any of `fifo_data[WIDTH-1:8]` nonzero is class OTHER.
  - Otherwise the class is `a` (0x61), `b` (0x62), `c` (0x63), `d` (0x64), or OTHER.
- States: IDLE, SEEN_A, SEEN_C. There is also a `b_cnt` register, 4 bits wide.
- IDLE:
  - `a` → SEEN_A, `b_cnt`=0.
  - Anything else → IDLE.
- SEEN_A:
  - `b` with `b_cnt` < MAX_B → SEEN_A, `b_cnt`+1.
  - `b` with `b_cnt` = MAX_B → IDLE.
  - `c` → SEEN_C.
  - `a` → SEEN_A, `b_cnt`=0. This restarts the pattern.
  - OTHER or `d` → IDLE.
- SEEN_C:
  - `d` → IDLE, and `match` is set to 1 on that edge.
  - `a` → SEEN_A, `b_cnt`=0.
  - Anything else → IDLE.
- Matching is non-overlapping by construction, because `d` cannot start a pattern.
- `match_count` increments on each match edge and holds at 2^CNT_W−1.
- `char_count` increments on each consume edge.
- `busy` = (state ≠ IDLE), registered with the state.

## Timing
- Reset values: `match`=0, `match_count`=0, `char_count`=0, `busy`=0, state=IDLE, `b_cnt`=0. `fifo_shift_out`=0 while `res_n`=0.
- Throughput: one character per cycle while the FIFO stays non-empty.
- Latency: `match` rises at the edge that consumes `d` and is high for exactly one cycle. It falls on the next edge unless that edge completes another match. Back-to-back matches are impossible because a match needs at least 3 characters.
- `match_count` updates on the same edge `match` rises.
- FIFO empty mid-pattern: state and `b_cnt` are held indefinitely. The pattern resumes when data arrives.
- `enable` low mid-pattern: same hold behaviour. No pop occurs.
- The FIFO may shift in and shift out on the same edge. This block only depends on `fifo_empty` and `fifo_data` as presented before the edge.
- `res_n` low mid-pattern: at the next edge everything returns to reset values. The head word is not popped during that edge.

## Configuration
- `REGEX_CASE_INSENSITIVE_EN`
  - Defined: characters 0x41–0x44 (`A`–`D`) are classified as `a`–`d`. The fold applies only when upper bits are zero.
  - Undefined: only lowercase 0x61–0x64 match, and uppercase letters are OTHER.
  - All timing is identical in both builds.

## Test plan
- Reset, then push `a`,`b`,`b`,`c`,`d` (16'h0061…16'h0064) into the FIFO, enable = 1:
  - 5 consecutive pops.
  - `match`=1 for one cycle on the 5th consume edge.
  - `match_count`=1, `char_count`=5, FIFO empty.
- Stream `a` followed by MAX_B+1 = 5 `b`, then `c`,`d`: no match, `match_count`=0, `char_count`=8.
- Stream `x`,`a`,`a`,`c`,`d`,`a`,`c`,`d` (0x78 first): two `match` pulses, `match_count`=2, `busy`=0 at end.
- Push `a`,`c`, then hold FIFO empty 10 cycles with `busy`=1, then push `d`:
  - `fifo_shift_out`=0 while empty.
  - Match on `d`, `match_count`=1.
- With CNT_W=2, feed 4 `acd` sequences: `match_count` saturates at 3, `char_count`=12 mod 4=0.
- Assert `res_n`=0 for one cycle after `a`,`c`: all outputs return to 0. A following `d` gives no match. With `REGEX_CASE_INSENSITIVE_EN`, `A`,`C`,`D` (16'h0041,16'h0043,16'h0044) gives one match; word 16'h0161 is OTHER.
